branch_history_ctrl: RTL and testbench

- Speculative global branch-history controller; sits directly upstream of the ordered branch-history queue.
- Owns the speculative global history register (GHR).
- Pushes a pre-branch history snapshot into the queue on each fetched branch, rolls the GHR and queue back on a mispredict, and frees queue rows on branch retire.
- Stalls fetch while the queue is full or a rollback is settling.

---
 rtl/branch_history_ctrl.sv | 133 +++++++++++++
 tb/tb_branch_history_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_ctrl.sv
// Speculative global-history controller for the ordered branch-history queue; BH_CTRL_STATS_EN adds saturating stat counters.
// Latency: obq_* and fetch_stall are combinational from inputs and current state; GHR/tag updates land next cycle.
// Backpressure: fetch_stall while the queue is full, during the one-cycle RECOVER, or on a same-cycle mispredict.
module branch_history_ctrl #(
    parameter int BH_WIDTH  = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 fetch_br_valid,
    input  logic                 fetch_br_pred_taken,
    output logic                 fetch_stall,
    output logic [TAG_WIDTH-1:0] fetch_br_tag,
    output logic [BH_WIDTH-1:0]  fetch_ghr,

    input  logic                 ex_br_valid,
    input  logic                 ex_br_mispredict,
    input  logic                 ex_br_taken,
    input  logic [TAG_WIDTH-1:0] ex_br_tag,
    input  logic [BH_WIDTH-1:0]  ex_br_history,

    input  logic                 rt_br_valid,
    input  logic [TAG_WIDTH-1:0] rt_br_tag,

    output logic                 obq_write_en,
    output logic [BH_WIDTH-1:0]  obq_bh_row,
    output logic                 obq_clear_en,
    output logic [TAG_WIDTH-1:0] obq_clear_index,
    output logic                 obq_shift_en,
    output logic [TAG_WIDTH-1:0] obq_shift_index
`ifdef BH_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_pushes,
    output logic [15:0]          stat_mispredicts
`endif
);

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t               state;
    logic [BH_WIDTH-1:0]  ghr;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [TAG_WIDTH-1:0] tail_tag;

    logic [TAG_WIDTH-1:0] occupancy;
    logic                 full;
    logic                 mispredict_now;
    logic                 stall_int;
    logic                 push_now;
    logic [TAG_WIDTH-1:0] clear_tag;
    logic [TAG_WIDTH-1:0] retire_next_head;
    logic                 unused_hist_msb;

    // The oldest history bit falls off the end when the resolved history is re-shifted.
    assign unused_hist_msb = ex_br_history[BH_WIDTH-1];

    assign occupancy        = tail_tag - head_tag;
    assign full             = (occupancy == {TAG_WIDTH{1'b1}});
    assign mispredict_now   = ex_br_valid & ex_br_mispredict;
    assign stall_int        = full | (state == RECOVER) | mispredict_now;
    assign push_now         = fetch_br_valid & ~stall_int & ~reset;
    assign clear_tag        = ex_br_tag + TAG_WIDTH'(1);
    assign retire_next_head = rt_br_tag + TAG_WIDTH'(1);

    // Everything towards the queue and fetch is forced quiet while reset is held,
    // since the queue-side inputs may still be toggling.
    always_comb begin
        fetch_stall     = 1'b0;
        obq_write_en    = 1'b0;
        obq_clear_en    = 1'b0;
        obq_clear_index = '0;
        obq_shift_en    = 1'b0;
        obq_shift_index = '0;
        if (!reset) begin
            fetch_stall     = stall_int;
            obq_write_en    = push_now;
            obq_clear_en    = mispredict_now;
            obq_clear_index = clear_tag;
            obq_shift_en    = rt_br_valid;
            obq_shift_index = rt_br_tag;
        end
    end

    assign obq_bh_row   = ghr;
    assign fetch_ghr    = ghr;
    assign fetch_br_tag = tail_tag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= NORMAL;
            ghr      <= '0;
            head_tag <= '0;
            tail_tag <= '0;
        end else begin
            // A mispredict wins over any push in the same cycle; the push is already stalled.
            if (mispredict_now) begin
                ghr      <= {ex_br_history[BH_WIDTH-2:0], ex_br_taken};
                tail_tag <= clear_tag;
                state    <= RECOVER;
            end else begin
                state <= NORMAL;
                if (push_now) begin
                    ghr      <= {ghr[BH_WIDTH-2:0], fetch_br_pred_taken};
                    tail_tag <= tail_tag + TAG_WIDTH'(1);
                end
            end
            if (rt_br_valid) begin
                head_tag <= retire_next_head;
            end
        end
    end

`ifdef BH_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_pushes      <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (push_now && (stat_pushes != 16'hFFFF)) begin
                stat_pushes <= stat_pushes + 16'd1;
            end
            if (mispredict_now && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_ctrl.sv
// Scoreboarded bench for branch_history_ctrl: expected outputs are queued when stimulus is driven.
module tb_branch_history_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       fetch_br_valid, fetch_br_pred_taken, fetch_stall;
    logic [3:0] fetch_br_tag;
    logic [7:0] fetch_ghr;
    logic       ex_br_valid, ex_br_mispredict, ex_br_taken;
    logic [3:0] ex_br_tag;
    logic [7:0] ex_br_history;
    logic       rt_br_valid;
    logic [3:0] rt_br_tag;
    logic       obq_write_en, obq_clear_en, obq_shift_en;
    logic [7:0] obq_bh_row;
    logic [3:0] obq_clear_index, obq_shift_index;

    branch_history_ctrl #(.BH_WIDTH(8), .TAG_WIDTH(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_br_valid      (fetch_br_valid),
        .fetch_br_pred_taken (fetch_br_pred_taken),
        .fetch_stall         (fetch_stall),
        .fetch_br_tag        (fetch_br_tag),
        .fetch_ghr           (fetch_ghr),
        .ex_br_valid         (ex_br_valid),
        .ex_br_mispredict    (ex_br_mispredict),
        .ex_br_taken         (ex_br_taken),
        .ex_br_tag           (ex_br_tag),
        .ex_br_history       (ex_br_history),
        .rt_br_valid         (rt_br_valid),
        .rt_br_tag           (rt_br_tag),
        .obq_write_en        (obq_write_en),
        .obq_bh_row          (obq_bh_row),
        .obq_clear_en        (obq_clear_en),
        .obq_clear_index     (obq_clear_index),
        .obq_shift_en        (obq_shift_en),
        .obq_shift_index     (obq_shift_index)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       we;
        logic [7:0] row;
        logic [3:0] tag;
        logic       ce;
        logic [3:0] ci;
        logic       se;
        logic [3:0] si;
        logic       stall;
        logic [7:0] ghr;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] m_ghr;
    logic [3:0] m_head, m_tail;
    logic       m_rec;

    function automatic obs_t observe();
        obs_t o;
        o.we    = obq_write_en;
        o.row   = obq_bh_row;
        o.tag   = fetch_br_tag;
        o.ce    = obq_clear_en;
        o.ci    = obq_clear_index;
        o.se    = obq_shift_en;
        o.si    = obq_shift_index;
        o.stall = fetch_stall;
        o.ghr   = fetch_ghr;
        return o;
    endfunction

    // Drives one cycle of stimulus, queues the expected outputs, then advances the model.
    task automatic drive(input logic fv, input logic fpt, input logic ev, input logic em,
                         input logic et, input logic [3:0] etag, input logic [7:0] eh,
                         input logic rv, input logic [3:0] rtag);
        obs_t e;
        logic mis, full, stall, push;
        fetch_br_valid = fv; fetch_br_pred_taken = fpt;
        ex_br_valid = ev; ex_br_mispredict = em; ex_br_taken = et;
        ex_br_tag = etag; ex_br_history = eh;
        rt_br_valid = rv; rt_br_tag = rtag;
        mis   = ev & em;
        full  = ((m_tail - m_head) == 4'hF);
        stall = full | m_rec | mis;
        push  = fv & ~stall;
        e.we = push; e.row = m_ghr; e.tag = m_tail; e.ce = mis; e.ci = etag + 4'd1;
        e.se = rv; e.si = rtag; e.stall = stall; e.ghr = m_ghr;
        sb.push_back(e);
        if (mis) begin
            m_ghr  = {eh[6:0], et};
            m_tail = etag + 4'd1;
        end else if (push) begin
            m_ghr  = {m_ghr[6:0], fpt};
            m_tail = m_tail + 4'd1;
        end
        m_rec = mis;
        if (rv) m_head = rtag + 4'd1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic push_br(input logic taken);
        drive(1'b1, taken, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic sample(output obs_t o, output obs_t e);
        @(negedge clock);
        o = observe();
        e = sb.pop_front();
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_ghr = '0; m_head = '0; m_tail = '0; m_rec = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        void'(sb.pop_back());
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b1;
        fetch_br_valid = 1'b1; fetch_br_pred_taken = 1'b1;
        ex_br_valid = 1'b1; ex_br_mispredict = 1'b1; ex_br_taken = 1'b1;
        ex_br_tag = 4'd7; ex_br_history = 8'hFF; rt_br_valid = 1'b1; rt_br_tag = 4'd5;
        model_reset();
        #3;
        o = observe();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", o); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle();
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_release: got %h expected %h", o, e); end
        next_cycle();
    endtask

    task automatic test_push_tnt();
        obs_t o, e;
        logic [7:0] rows [3] = '{8'h00, 8'h01, 8'h02};
        for (int i = 0; i < 3; i++) begin
            push_br(i != 1);
            sample(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL tnt_sb[%0d]: got %h expected %h", i, o, e); end
            n_checks++;
            if (o.row !== rows[i] || o.tag !== 4'(i) || o.we !== 1'b1) begin
                n_fail++; $display("FAIL tnt_row[%0d]: got row %h tag %0d we %b expected row %h tag %0d we 1",
                                   i, o.row, o.tag, o.we, rows[i], i);
            end
            next_cycle();
        end
        idle();
        sample(o, e);
        n_checks++;
        if (o.ghr !== 8'h05) begin n_fail++; $display("FAIL tnt_ghr: got %h expected 05", o.ghr); end
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL tnt_idle_sb: got %h expected %h", o, e); end
        next_cycle();
    endtask

    task automatic test_mispredict();
        obs_t o, e;
        for (int i = 0; i < 2; i++) begin
            push_br(1'b0);
            sample(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL mis_push_sb[%0d]: got %h expected %h", i, o, e); end
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'h02, 1'b0, 4'd0);
        sample(o, e);
        n_checks++;
        if (o.ce !== 1'b1 || o.ci !== 4'd3 || o.we !== 1'b0 || o.stall !== 1'b1) begin
            n_fail++; $display("FAIL mis_clear: got ce %b ci %0d we %b stall %b expected ce 1 ci 3 we 0 stall 1",
                               o.ce, o.ci, o.we, o.stall);
        end
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mis_sb: got %h expected %h", o, e); end
        next_cycle();
        push_br(1'b1);
        sample(o, e);
        n_checks++;
        if (o.ghr !== 8'h04 || o.tag !== 4'd3 || o.stall !== 1'b1 || o.we !== 1'b0) begin
            n_fail++; $display("FAIL mis_recover: got ghr %h tag %0d stall %b we %b expected ghr 04 tag 3 stall 1 we 0",
                               o.ghr, o.tag, o.stall, o.we);
        end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o.stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall_drop: got %b expected 0", o.stall); end
        next_cycle();
        // Two mispredicts back to back: the second lands in RECOVER and extends it.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h02, 1'b0, 4'd0);
        sample(o, e);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 4'd0);
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_mis_sb: got %h expected %h", o, e); end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o.stall !== 1'b1 || o.ghr !== 8'h01 || o.tag !== 4'd1) begin
            n_fail++; $display("FAIL b2b_recover: got stall %b ghr %h tag %0d expected stall 1 ghr 01 tag 1",
                               o.stall, o.ghr, o.tag);
        end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_normal_sb: got %h expected %h", o, e); end
        next_cycle();
    endtask

    task automatic test_full_wrap();
        obs_t o, e;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            push_br(i[0]);
            sample(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL full_sb[%0d]: got %h expected %h", i, o, e); end
            next_cycle();
        end
        push_br(1'b1);
        sample(o, e);
        n_checks++;
        if (o.stall !== 1'b1 || o.we !== 1'b0) begin
            n_fail++; $display("FAIL full_stall: got stall %b we %b expected stall 1 we 0", o.stall, o.we);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
        sample(o, e);
        n_checks++;
        if (o.se !== 1'b1 || o.si !== 4'd0 || o.stall !== 1'b1) begin
            n_fail++; $display("FAIL retire: got se %b si %0d stall %b expected se 1 si 0 stall 1", o.se, o.si, o.stall);
        end
        next_cycle();
        push_br(1'b1);
        sample(o, e);
        n_checks++;
        if (o.stall !== 1'b0 || o.we !== 1'b1 || o.tag !== 4'd15) begin
            n_fail++; $display("FAIL wrap_push: got stall %b we %b tag %0d expected stall 0 we 1 tag 15",
                               o.stall, o.we, o.tag);
        end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o.tag !== 4'd0) begin n_fail++; $display("FAIL wrap_tail: got %0d expected 0", o.tag); end
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 8'hAA, 1'b0, 4'd0);
        sample(o, e);
        n_checks++;
        if (o.ce !== 1'b1 || o.ci !== 4'd0) begin
            n_fail++; $display("FAIL wrap_clear: got ce %b ci %0d expected ce 1 ci 0", o.ce, o.ci);
        end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL wrap_recover_sb: got %h expected %h", o, e); end
        next_cycle();
    endtask

    task automatic test_same_cycle();
        obs_t o, e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push_br(1'b1);
            sample(o, e);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 8'h03, 1'b1, 4'd0);
        sample(o, e);
        n_checks++;
        if (o.we !== 1'b0 || o.ci !== 4'd2 || o.si !== 4'd0 || o.se !== 1'b1 || o.ce !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle: got we %b ce %b ci %0d se %b si %0d expected we 0 ce 1 ci 2 se 1 si 0",
                               o.we, o.ce, o.ci, o.se, o.si);
        end
        next_cycle();
        idle();
        sample(o, e);
        n_checks++;
        if (o.tag !== 4'd2 || o.ghr !== 8'h07) begin
            n_fail++; $display("FAIL same_cycle_next: got tag %0d ghr %h expected tag 2 ghr 07", o.tag, o.ghr);
        end
        next_cycle();
        // head=1, tail=2: exactly 14 more pushes fit before the queue reports full.
        for (int i = 0; i < 15; i++) begin
            push_br(1'b0);
            sample(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL head_probe_sb[%0d]: got %h expected %h", i, o, e); end
            if (i >= 13) begin
                n_checks++;
                if (o.stall !== (i == 14)) begin
                    n_fail++; $display("FAIL head_probe_stall[%0d]: got %b expected %b", i, o.stall, i == 14);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_recover();
        obs_t o, e;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h10, 1'b0, 4'd0);
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rr_mis_sb: got %h expected %h", o, e); end
        next_cycle();
        fetch_br_valid = 1'b1; ex_br_valid = 1'b1; ex_br_mispredict = 1'b1;
        ex_br_tag = 4'd6; rt_br_valid = 1'b1; rt_br_tag = 4'd9;
        #1 reset = 1'b1;
        #1;
        o = observe();
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL rr_async_outputs: got %h expected 0", o); end
        idle();
        void'(sb.pop_back());
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle();
        sample(o, e);
        n_checks++;
        if (o.stall !== 1'b0 || o.ghr !== 8'h00 || o.tag !== 4'd0) begin
            n_fail++; $display("FAIL rr_release: got stall %b ghr %h tag %0d expected stall 0 ghr 00 tag 0",
                               o.stall, o.ghr, o.tag);
        end
        next_cycle();
        push_br(1'b1);
        sample(o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rr_push_sb: got %h expected %h", o, e); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_push_tnt();
        test_mispredict();
        test_full_wrap();
        test_same_cycle();
        test_reset_in_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
